// File: rtl/cle_label_stat.sv
// Label statistics: scans the 32x32 label map one pixel per cycle and reports
// the area and inclusive bounding box of one requested label.
//   state | meaning
//   IDLE  | waiting for start, sram_a parked at 0
//   SCAN  | issuing addresses 0..N-1, capturing returned words
//   DRAIN | last address issued, waiting for its data word
module cle_label_stat #(
  parameter int IMG_W_LOG2 = 5,
  parameter int IMG_H_LOG2 = 5,
  parameter int LABEL_W    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [LABEL_W-1:0]               label_id,
  input  logic [LABEL_W-1:0]               sram_q,
  output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] sram_a,
  output logic                             sram_wen,
  output logic                             busy,
  output logic                             done,
  output logic                             found,
  output logic [IMG_W_LOG2+IMG_H_LOG2:0]   area,
  output logic [IMG_W_LOG2-1:0]            x_min,
  output logic [IMG_W_LOG2-1:0]            x_max,
  output logic [IMG_H_LOG2-1:0]            y_min,
  output logic [IMG_H_LOG2-1:0]            y_max
);

  localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t state, state_nx;

  logic [LABEL_W-1:0]    lbl;
  logic [AW-1:0]         tag;
  logic                  tag_vld;
  logic [AW:0]           cnt, cnt_nx;
  logic [IMG_W_LOG2-1:0] xmn, xmx, xmn_nx, xmx_nx, tx;
  logic [IMG_H_LOG2-1:0] ymn, ymx, ymn_nx, ymx_nx, ty;
  logic                  hit;
  logic                  any_nx;

  assign sram_wen = 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (sram_a == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tag is the address the SRAM sampled one edge ago, i.e. the one sram_q belongs to
  always_comb begin
    tx     = tag[IMG_W_LOG2-1:0];
    ty     = tag[AW-1:IMG_W_LOG2];
    hit    = tag_vld && (sram_q == lbl);
    cnt_nx = hit ? cnt + 1'b1 : cnt;
    xmn_nx = (hit && tx < xmn) ? tx : xmn;
    xmx_nx = (hit && tx > xmx) ? tx : xmx;
    ymn_nx = (hit && ty < ymn) ? ty : ymn;
    ymx_nx = (hit && ty > ymx) ? ty : ymx;
    any_nx = (cnt_nx != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_a  <= '0;
      lbl     <= '0;
      tag     <= '0;
      tag_vld <= 1'b0;
      cnt     <= '0;
      xmn     <= '1;
      xmx     <= '0;
      ymn     <= '1;
      ymx     <= '0;
      done    <= 1'b0;
      found   <= 1'b0;
      area    <= '0;
      x_min   <= '0;
      x_max   <= '0;
      y_min   <= '0;
      y_max   <= '0;
    end else begin
      tag     <= sram_a;
      tag_vld <= (state == SCAN);
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lbl    <= label_id;
            sram_a <= '0;
            cnt    <= '0;
            xmn    <= '1;
            xmx    <= '0;
            ymn    <= '1;
            ymx    <= '0;
          end
        end
        SCAN: begin
          if (sram_a != LAST_ADDR) sram_a <= sram_a + 1'b1;
          cnt <= cnt_nx;
          xmn <= xmn_nx;
          xmx <= xmx_nx;
          ymn <= ymn_nx;
          ymx <= ymx_nx;
        end
        DRAIN: begin
          cnt    <= cnt_nx;
          xmn    <= xmn_nx;
          xmx    <= xmx_nx;
          ymn    <= ymn_nx;
          ymx    <= ymx_nx;
          sram_a <= '0;
          done   <= 1'b1;
          // the min/max sentinels must never leak out for an absent label
          found  <= any_nx;
          area   <= cnt_nx;
          x_min  <= any_nx ? xmn_nx : '0;
          x_max  <= any_nx ? xmx_nx : '0;
          y_min  <= any_nx ? ymn_nx : '0;
          y_max  <= any_nx ? ymx_nx : '0;
        end
        default: sram_a <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_label_stat.sv
// Scoreboard bench for cle_label_stat: a driver pushes reference results computed
// from the label map, a negedge monitor pops and compares them on every done.
module tb_cle_label_stat;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  label_id = '0;
  logic [7:0]  sram_q = '0;
  logic [9:0]  sram_a;
  logic        sram_wen, busy, done, found;
  logic [10:0] area;
  logic [4:0]  x_min, x_max, y_min, y_max;

  cle_label_stat dut (
    .clk(clk), .reset(reset), .start(start), .label_id(label_id), .sram_q(sram_q),
    .sram_a(sram_a), .sram_wen(sram_wen), .busy(busy), .done(done), .found(found),
    .area(area), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    int area;
    int found;
    int x0, x1, y0, y1;
    int acc;
  } exp_t;

  logic [7:0] mem [1024];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cur_acc = 0;
  exp_t q[$];
  exp_t last = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sram_q <= mem[sram_a];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] lbl, input int acc);
    exp_t e;
    int n = 0, x0 = 32, x1 = -1, y0 = 32, y1 = -1;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        if (mem[y*32 + x] == lbl) begin
          n++;
          if (x < x0) x0 = x;
          if (x > x1) x1 = x;
          if (y < y0) y0 = y;
          if (y > y1) y1 = y;
        end
    e.area = n;
    e.found = (n > 0) ? 1 : 0;
    e.x0 = (n > 0) ? x0 : 0;
    e.x1 = (n > 0) ? x1 : 0;
    e.y0 = (n > 0) ? y0 : 0;
    e.y1 = (n > 0) ? y1 : 0;
    e.acc = acc;
    return e;
  endfunction

  // monitor: results on done, address/hold behaviour while busy
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (q.size() == 0) check("done_unexpected", int'(done), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("latency", cyc - e.acc, 1025);
          check("area", int'(area), e.area);
          check("found", int'(found), e.found);
          check("x_min", int'(x_min), e.x0);
          check("x_max", int'(x_max), e.x1);
          check("y_min", int'(y_min), e.y0);
          check("y_max", int'(y_max), e.y1);
          check("busy_at_done", int'(busy), 0);
          last = e;
        end
      end else if (busy) begin
        int k;
        k = cyc - cur_acc;
        if (k > 1023) k = 1023;
        check("sram_a", int'(sram_a), k);
        check("hold_area", int'(area), last.area);
        check("hold_bbox", int'({found, x_min, x_max, y_min, y_max}),
              int'({last.found[0], 5'(last.x0), 5'(last.x1), 5'(last.y0), 5'(last.y1)}));
      end
    end
  end

  task automatic issue_now(input logic [7:0] lbl);
    label_id = lbl;
    start = 1'b1;
    if (!busy) begin
      q.push_back(model(lbl, cyc + 1));
      cur_acc = cyc + 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [7:0] lbl);
    @(negedge clk);
    issue_now(lbl);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("timeout_pending", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_scan_cycle(input int k);
    int n = 0;
    while ((cyc - cur_acc) < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if ((cyc - cur_acc) < k) check("timeout_scan", cyc - cur_acc, k);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 1024; i++) begin
      case (mode)
        0:       mem[i] = 8'd0;
        1:       mem[i] = 8'($urandom_range(0, 3));
        default: mem[i] = ($urandom_range(0, 49) == 0) ? 8'd6 : 8'd0;
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_area"}, int'(area), 0);
    check({tag, "_bbox"}, int'({x_min, x_max, y_min, y_max}), 0);
    check({tag, "_sram_a"}, int'(sram_a), 0);
    check({tag, "_sram_wen"}, int'(sram_wen), 1);
  endtask

  initial begin
    int n;
    fill(0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // all-zero map: absent label, then background label
    issue(8'd1);
    wait_idle();
    issue(8'd0);
    wait_idle();

    // three scattered pixels
    fill(0);
    mem[2*32 + 3]  = 8'd5;
    mem[7*32 + 10] = 8'd5;
    mem[20*32 + 4] = 8'd5;
    issue(8'd5);
    wait_idle();

    // first and last addresses only
    fill(0);
    mem[0]    = 8'd9;
    mem[1023] = 8'd9;
    issue(8'd9);
    wait_idle();

    for (int r = 0; r < 3; r++) begin
      fill(1);
      issue(8'($urandom_range(0, 3)));
      wait_idle();
    end
    fill(2);
    issue(8'd6);
    wait_idle();

    // start while busy is ignored; start in the done cycle is accepted back-to-back
    fill(1);
    issue(8'd2);
    wait_scan_cycle(500);
    label_id = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
    issue_now(8'd1);
    wait_idle();

    // reset mid-scan aborts and clears everything
    fill(1);
    issue(8'd3);
    wait_scan_cycle(300);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    q.delete();
    last = '{default: 0};
    @(negedge clk);
    reset = 1'b1;
    issue(8'd1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
